// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage; owns HI/LO and
// requests a front-end stall while a HI/LO consumer waits on a busy operation.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_rs,
  input  logic [WIDTH-1:0] md_rt,
  input  logic             hilo_use,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_done
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic               done_q, done_d, busy_q, busy_d;

  logic               is_mul, is_div_op, is_signed, accept;
  logic [WIDTH-1:0]   rs_abs, rt_abs, quo, rem;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand decode, magnitudes and the per-iteration datapath
  always_comb begin
    is_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div_op = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    accept    = (state_q == S_IDLE) && md_start && !cancel && (is_mul || is_div_op);
    rs_abs    = (is_signed && md_rs[WIDTH-1]) ? -md_rs : md_rs;
    rt_abs    = (is_signed && md_rt[WIDTH-1]) ? -md_rt : md_rt;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_sh - {1'b0, op_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_CALC;
          cnt_d     = CNT_W'(WIDTH);
          op_d      = is_mul ? rs_abs : rt_abs;
          acc_d     = is_mul ? {{WIDTH{1'b0}}, rt_abs} : {{WIDTH{1'b0}}, rs_abs};
          is_div_d  = is_div_op;
          neg_d     = is_signed && (md_rs[WIDTH-1] ^ md_rt[WIDTH-1]);
          neg_rem_d = is_signed && md_rs[WIDTH-1];
          dz_d      = is_div_op && (md_rt == '0);
        end else if (md_start && !cancel) begin
          if (md_op == OP_MTHI) hi_d = md_rs;
          if (md_op == OP_MTLO) lo_d = md_rs;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Divide by zero keeps the all-ones quotient unsigned-looking
          lo_d = dz_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Exception abort wins over any HI/LO write in flight
    if (cancel && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign stall_req = busy_q & hilo_use;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign md_done   = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, results, stall, cancel and reset.
module tb_ex_muldiv_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic             clk = 1'b0;
  logic             reset;
  logic             md_start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] md_rs, md_rt;
  logic             hilo_use, cancel;
  logic             busy, stall_req, md_done;
  logic [WIDTH-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
    .md_rs(md_rs), .md_rt(md_rt), .hilo_use(hilo_use), .cancel(cancel),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .md_done(md_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; returns just after the accept edge (cycle T+1)
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    md_start = 1'b1; md_op = op; md_rs = rs; md_rt = rt; hilo_use = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = OP_NONE; hilo_use = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    issue(op, rs, rt);
    for (int c = 1; c <= 60 && done_at == 0; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (md_done) begin
        done_at = c;
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_lat"}, 32'(done_at), 32'd34);
    check({tag, "_busy_cyc"}, 32'(busy_n), 32'd33);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(md_done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int stall_n;
    int early_n;
    int ev_n;
    reset = 1'b1; md_start = 1'b0; md_op = OP_NONE; md_rs = '0; md_rt = '0;
    hilo_use = 1'b0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(md_done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mult_m1x2",   OP_MULT,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_m1x2",  OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_zero",   OP_MULT,  32'hFFFF_FFFB, 32'h0, 32'h0,         32'h0);
    run_op("div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100d7",  OP_DIVU,  32'd100,       32'd7, 32'd2,         32'd14);
    run_op("divu_by0",    OP_DIVU,  32'd7,         32'h0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_by0_neg", OP_DIV,   32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // mfhi arrives at T+5 behind a signed mult of 3 * -4
    stall_n = 0;
    early_n = 0;
    issue(OP_MULT, 32'd3, 32'hFFFF_FFFC);
    for (int c = 1; c <= 34; c++) begin
      hilo_use = (c >= 5);
      @(negedge clk);
      if (c < 5 && stall_req) early_n++;
      if (c >= 5 && c <= 33 && stall_req) stall_n++;
      if (c == 34) begin
        check("stall_release", 32'(stall_req), 32'd0);
        check("stall_done", 32'(md_done), 32'd1);
        check("stall_hi", hi, 32'hFFFF_FFFF);
        check("stall_lo", lo, 32'hFFFF_FFF4);
      end
      @(posedge clk); #1;
    end
    hilo_use = 1'b0;
    check("stall_unrelated", 32'(early_n), 32'd0);
    check("stall_cycles", 32'(stall_n), 32'd29);

    // mthi/mtlo preload
    issue(OP_MTHI, 32'h1234, 32'h0);
    @(negedge clk);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_done", 32'(md_done), 32'd0);
    @(posedge clk); #1;
    issue(OP_MTLO, 32'h5678, 32'h0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi", hi, 32'h1234);
    @(posedge clk); #1;

    // cancel asserted during T+10 of a mult
    issue(OP_MULT, 32'd7, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", 32'(busy), 32'd0);
    ev_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_done || busy) ev_n++;
    end
    check("cancel_quiet", 32'(ev_n), 32'd0);
    check("cancel_hi", hi, 32'h1234);
    check("cancel_lo", lo, 32'h5678);
    @(posedge clk); #1;

    // async reset at T+10 of a mult
    issue(OP_MULT, 32'd5, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #2;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst_multu", OP_MULTU, 32'd7, 32'd6, 32'h0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes operands and decoded mul/div ops from the ID/EX register outputs.
- Owns the architectural HI/LO registers and services MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Raises a stall request so the hazard unit freezes IF/ID and bubbles ID/EX while a HI/LO consumer waits on a busy operation.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- md_start  in  1  EX-stage instruction is valid and uses the unit.
- md_op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; others are none.
- md_rs  in  WIDTH  forwarded rs value (multiplicand/dividend/mt source).
- md_rt  in  WIDTH  forwarded rt value (multiplier/divisor).
- hilo_use  in  1  EX-stage instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- cancel  in  1  exception (illop/xadr) abort.
- busy  out  1  operation in progress.
- stall_req  out  1  hold the front of the pipeline.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- md_done  out  1  one-cycle pulse when HI/LO are written by mult/div.

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, md_done=0, counter=0, all internal accumulators 0. Reset mid-operation aborts immediately.
- States:
  - IDLE: accepts start.
  - CALC: runs iterations.
  - FIX: sign correction and HI/LO write.
- Accept condition: cycle T with state=IDLE, md_start=1, cancel=0, md_op in {mult,multu,div,divu}.
  - Operands latched at the T edge.
  - Signed ops store |rs|, |rt| and the result signs.
  - Counter loaded with WIDTH.
- CALC: one radix-2 iteration per cycle for WIDTH cycles (T+1..T+WIDTH).
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract giving a WIDTH quotient and remainder.
  - Leave CALC when the counter reaches 0.
- FIX (cycle T+WIDTH+1):
  - Negate the product if the signs differ (signed mult).
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign (signed div).
  - Write hi=product[2W-1:W], lo=product[W-1:0]; or hi=remainder, lo=quotient.
  - Return to IDLE.
- md_done = 1 in cycle T+WIDTH+2 only; HI/LO are valid from that cycle.
- busy = 1 in cycles T+1..T+WIDTH+1 (state != IDLE).
- stall_req = busy & hilo_use (combinational). A new mul/div, mf*, or mt* in EX waits; unrelated instructions proceed.
- md_start while busy is ignored. stall_req guarantees the instruction is re-presented.
- mthi/mtlo in IDLE: hi (or lo) <= md_rs at the next edge, with no busy and no md_done.
- Divide by zero (rt=0), signed or unsigned: lo=all ones, hi=md_rs (original value). Full latency still applies.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of magnitude arithmetic with no special case.
- Signed mult/div with a zero result: no negative zero issue; two's complement negate of 0 is 0.
- cancel in IDLE blocks the accept. cancel in CALC/FIX forces IDLE at the next edge, with HI/LO unchanged and no md_done. cancel has priority over the FIX write in the same cycle.
- Single outstanding operation; no queueing.

Test Plan:
- Reset asserted mid-CALC (cycle T+10), released -> hi=lo=0, busy=0 immediately; next start proceeds normally.
- mult rs=0xFFFFFFFF rt=0x00000002 -> busy for 33 cycles; md_done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mult in progress, then mfhi presented (hilo_use=1) at T+5 -> stall_req=1 through T+33, 0 at T+34 with the new hi visible. An unrelated op with hilo_use=0 -> stall_req=0.
- cancel at T+10 of a mult with hi=0x1234, lo=0x5678 preloaded via mthi/mtlo -> IDLE at T+11, hi/lo unchanged, no md_done.
